// File: rtl/mm_requant_if.sv
// AXI-stream style handshake bundle used for both the accumulator input and the int8 output.
interface mm_requant_if #(
    parameter int unsigned DATA_W = 32
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/mm_requant.sv
// Streaming per-column requantizer: acc * mult, round-half-up arithmetic shift, saturate to D_W.
// Three-stage pipeline under a single global stall driven by the output register.
module mm_requant #(
    parameter int unsigned D_W          = 8,
    parameter int unsigned D_W_ACC      = 32,
    parameter int unsigned MULT_W       = 16,
    parameter int unsigned SHIFT_W      = 6,
    parameter int unsigned MATRIXSIZE_W = 16,
    parameter int unsigned MAX_COLS     = 1024
) (
    input  logic                         mm_clk,
    input  logic                         mm_rst_n,
    mm_requant_if.slave                  s_axis,
    mm_requant_if.master                 m_axis,
    input  logic [MATRIXSIZE_W-1:0]      M3,
    input  logic                         cfg_we,
    input  logic [$clog2(MAX_COLS)-1:0]  cfg_addr,
    input  logic [MULT_W-1:0]            cfg_mult,
    input  logic [SHIFT_W-1:0]           cfg_shift,
    output logic [31:0]                  sat_count
);
    localparam int unsigned COL_W  = $clog2(MAX_COLS);
    localparam int unsigned PROD_W = D_W_ACC + MULT_W;
    localparam int unsigned COEF_W = MULT_W + SHIFT_W;
    localparam logic signed [PROD_W:0] SAT_MAX = (PROD_W+1)'((1 << (D_W - 1)) - 1);
    localparam logic signed [PROD_W:0] SAT_MIN = -SAT_MAX - 1;

    logic                     w_ce;
    logic                     w_accept;
    logic [MATRIXSIZE_W-1:0]  w_last_col;
    logic [COL_W-1:0]         r_col;
    logic [COEF_W-1:0]        r_coef_mem [MAX_COLS];

    logic                     r_s1_valid;
    logic signed [D_W_ACC-1:0] r_s1_acc;
    logic                     r_s1_last;
    logic [MULT_W-1:0]        r_s1_mult;
    logic [SHIFT_W-1:0]       r_s1_shift;

    logic                     r_s2_valid;
    logic signed [PROD_W-1:0] r_s2_prod;
    logic [SHIFT_W-1:0]       r_s2_shift;
    logic                     r_s2_last;

    logic                     r_out_valid;
    logic [D_W-1:0]           r_out_data;
    logic                     r_out_last;
    logic                     r_out_sat;
    logic [31:0]              r_sat_count;

    logic signed [PROD_W-1:0] w_acc_x;
    logic signed [PROD_W-1:0] w_mult_x;
    logic signed [PROD_W-1:0] w_prod;
    logic [SHIFT_W-1:0]       w_sh;
    logic signed [PROD_W:0]   w_half;
    logic signed [PROD_W:0]   w_sum;
    logic signed [PROD_W:0]   w_rnd;
    logic [D_W-1:0]           w_res;
    logic                     w_clamp;

    assign w_ce            = ~r_out_valid | m_axis.tready;
    assign w_accept        = s_axis.tvalid & w_ce;
    assign s_axis.tready   = w_ce;
    assign m_axis.tvalid   = r_out_valid;
    assign m_axis.tlast    = r_out_last;
    assign m_axis.tdata    = {{(32-D_W){r_out_data[D_W-1]}}, r_out_data};
    assign sat_count       = r_sat_count;
    // M3=0 behaves as a single-column matrix
    assign w_last_col      = (M3 == '0) ? '0 : M3 - MATRIXSIZE_W'(1);

    always_ff @(posedge mm_clk or negedge mm_rst_n) begin
        if (!mm_rst_n) begin
            r_col <= '0;
        end else if (w_accept) begin
            if (s_axis.tlast || MATRIXSIZE_W'(r_col) >= w_last_col) r_col <= '0;
            else                                                    r_col <= r_col + COL_W'(1);
        end
    end

    // Coefficient table and its registered read; read-during-write yields the old entry
    always_ff @(posedge mm_clk) begin
        if (cfg_we) r_coef_mem[cfg_addr] <= {cfg_mult, cfg_shift};
        if (w_ce) {r_s1_mult, r_s1_shift} <= r_coef_mem[r_col];
    end

    always_comb begin
        w_acc_x  = PROD_W'(r_s1_acc);
        w_mult_x = $signed(PROD_W'(r_s1_mult));
        w_prod   = w_acc_x * w_mult_x;
    end

    always_comb begin
        w_sh = (r_s2_shift > SHIFT_W'(PROD_W - 1)) ? SHIFT_W'(PROD_W - 1) : r_s2_shift;
        w_half = '0;
        if (w_sh != '0) w_half = (PROD_W+1)'(1) << (w_sh - SHIFT_W'(1));
        w_sum = {r_s2_prod[PROD_W-1], r_s2_prod} + w_half;
        w_rnd = w_sum >>> w_sh;
        w_clamp = 1'b0;
        w_res = w_rnd[D_W-1:0];
        if (w_rnd > SAT_MAX) begin
            w_res   = SAT_MAX[D_W-1:0];
            w_clamp = 1'b1;
        end else if (w_rnd < SAT_MIN) begin
            w_res   = SAT_MIN[D_W-1:0];
            w_clamp = 1'b1;
        end
    end

    always_ff @(posedge mm_clk or negedge mm_rst_n) begin
        if (!mm_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_acc    <= '0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_shift  <= '0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_ce) begin
            r_s1_valid  <= s_axis.tvalid;
            r_s1_acc    <= s_axis.tdata[D_W_ACC-1:0];
            r_s1_last   <= s_axis.tlast;
            r_s2_valid  <= r_s1_valid;
            r_s2_prod   <= w_prod;
            r_s2_shift  <= r_s1_shift;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_s2_valid;
            r_out_data  <= w_res;
            r_out_last  <= r_s2_last;
            r_out_sat   <= w_clamp;
        end
    end

    always_ff @(posedge mm_clk or negedge mm_rst_n) begin
        if (!mm_rst_n) begin
            r_sat_count <= '0;
        end else if (r_out_valid && m_axis.tready && r_out_sat && r_sat_count != '1) begin
            r_sat_count <= r_sat_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_mm_requant.sv
// Scoreboard bench for mm_requant: a behavioural model predicts each output at accept time.
module tb_mm_requant;
    logic        mm_clk;
    logic        mm_rst_n;
    logic [15:0] M3;
    logic        cfg_we;
    logic [9:0]  cfg_addr;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic [31:0] sat_count;

    mm_requant_if s_axis ();
    mm_requant_if m_axis ();

    mm_requant dut (
        .mm_clk    (mm_clk),
        .mm_rst_n  (mm_rst_n),
        .s_axis    (s_axis),
        .m_axis    (m_axis),
        .M3        (M3),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .sat_count (sat_count)
    );

    initial mm_clk = 1'b0;
    always #5 mm_clk = ~mm_clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        bit          sat;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          tb_col = 0;
    int          exp_sat = 0;
    bit          lat_chk = 0;
    logic [15:0] tb_mult [1024];
    logic [5:0]  tb_shift [1024];

    always @(posedge mm_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input int acc, input int unsigned mult,
                                          input int unsigned sh, output bit sat);
        longint      p;
        longint      r;
        int unsigned s;
        p = longint'(acc) * longint'(mult);
        s = (sh > 47) ? 47 : sh;
        if (s == 0) r = p;
        else        r = (p + (longint'(1) <<< (s - 1))) >>> s;
        sat = 1'b0;
        if (r > 127) begin
            r = 127;
            sat = 1'b1;
        end else if (r < -128) begin
            r = -128;
            sat = 1'b1;
        end
        return 32'(r);
    endfunction

    task automatic push_exp(input logic [31:0] acc, input logic last);
        exp_t e;
        int   m;
        m = (M3 == 0) ? 1 : int'(M3);
        e.data = model(int'(acc), int'(tb_mult[tb_col]), int'(tb_shift[tb_col]), e.sat);
        e.last = last;
        e.cyc  = cyc;
        q.push_back(e);
        if (last || tb_col >= m - 1) tb_col = 0;
        else                         tb_col = tb_col + 1;
    endtask

    // Caller is always just after a rising edge
    task automatic send(input logic [31:0] acc, input logic last);
        bit ok;
        ok = 1'b0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = acc;
        s_axis.tlast  = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge mm_clk);
            if (s_axis.tready) begin
                ok = 1'b1;
                push_exp(acc, last);
            end
            @(posedge mm_clk);
            #1;
        end
        if (!ok) check_eq("accept_timeout", {31'b0, s_axis.tready}, 32'd1);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input logic [15:0] mult, input logic [5:0] sh);
        cfg_we    = 1'b1;
        cfg_addr  = 10'(addr);
        cfg_mult  = mult;
        cfg_shift = sh;
        @(posedge mm_clk);
        #1;
        cfg_we = 1'b0;
        tb_mult[addr]  = mult;
        tb_shift[addr] = sh;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge mm_clk);
        check_eq({"drain_", tag}, q.size(), 32'd0);
        repeat (2) @(negedge mm_clk);
        check_eq({"sat_count_", tag}, sat_count, exp_sat);
        @(posedge mm_clk);
        #1;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge mm_clk);
            #1;
        end
    endtask

    always @(negedge mm_clk) begin
        if (mm_rst_n && m_axis.tvalid && m_axis.tready) begin
            if (q.size() == 0) begin
                check_eq("spurious_out_valid", {31'b0, m_axis.tvalid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_eq("out_data", m_axis.tdata, e.data);
                check_eq("out_last", {31'b0, m_axis.tlast}, {31'b0, e.last});
                if (lat_chk) check_eq("latency", cyc - e.cyc, 32'd3);
                if (e.sat) exp_sat++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mm_rst_n      = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
        M3            = 16'd1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_mult      = '0;
        cfg_shift     = '0;
        #1 mm_rst_n = 1'b0;
        #1;
        check_eq("rst_m_tvalid", {31'b0, m_axis.tvalid}, 32'd0);
        check_eq("rst_m_tdata", m_axis.tdata, 32'd0);
        check_eq("rst_m_tlast", {31'b0, m_axis.tlast}, 32'd0);
        check_eq("rst_sat_count", sat_count, 32'd0);
        check_eq("rst_s_tready", {31'b0, s_axis.tready}, 32'd1);
        repeat (3) @(negedge mm_clk);
        mm_rst_n = 1'b1;
        @(posedge mm_clk);
        #1;

        // Basic scale with latency check
        cfg_write(0, 16'd3, 6'd2);
        lat_chk = 1'b1;
        send(32'd100, 1'b1);
        drain("basic");
        lat_chk = 1'b0;

        // Half rounds up
        cfg_write(0, 16'd1, 6'd1);
        send(-32'sd5, 1'b1);
        send(32'd5, 1'b1);
        drain("round");

        // Saturation both ways
        cfg_write(0, 16'd1, 6'd0);
        send(32'd1000, 1'b1);
        send(-32'sd1000, 1'b1);
        drain("sat2");
        cfg_write(0, 16'hFFFF, 6'd0);
        send(32'h7FFF_FFFF, 1'b1);
        // Shift amount beyond 47 is clamped
        cfg_write(0, 16'hFFFF, 6'd63);
        send(32'h7FFF_FFFF, 1'b1);
        send(32'h8000_0000, 1'b1);
        drain("clamp");

        // M3=0 stays on column 0
        M3 = 16'd0;
        cfg_write(0, 16'd5, 6'd0);
        cfg_write(1, 16'd7, 6'd0);
        for (int i = 0; i < 3; i++) send(32'd3, 1'b0);
        send(32'd3, 1'b1);
        drain("m3_zero");

        // Per-column coefficients over two rows, then a fresh matrix
        M3 = 16'd4;
        for (int c = 0; c < 4; c++) cfg_write(c, 16'(c + 1), 6'd0);
        for (int i = 0; i < 8; i++) send(32'd10, i == 7);
        send(32'd10, 1'b0);
        send(32'd10, 1'b1);
        drain("cols");

        // Backpressure with random valid gaps
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(32'(i * 7 - 40), i == 15);
                    idle_gap();
                end
            end
            begin
                for (int i = 0; i < 100 && !m_axis.tvalid; i++) @(negedge mm_clk);
                @(posedge mm_clk);
                #1;
                m_axis.tready = 1'b0;
                repeat (5) begin
                    @(negedge mm_clk);
                    if (m_axis.tvalid) check_eq("stall_s_tready", {31'b0, s_axis.tready}, 32'd0);
                end
                @(posedge mm_clk);
                #1;
                m_axis.tready = 1'b1;
            end
        join
        drain("stall");

        // Async reset with beats in flight
        for (int i = 0; i < 3; i++) send(32'd10, 1'b0);
        #2 mm_rst_n = 1'b0;
        #1;
        check_eq("midrst_m_tvalid", {31'b0, m_axis.tvalid}, 32'd0);
        check_eq("midrst_sat_count", sat_count, 32'd0);
        q.delete();
        tb_col  = 0;
        exp_sat = 0;
        @(negedge mm_clk);
        mm_rst_n = 1'b1;
        @(posedge mm_clk);
        #1;
        send(32'd10, 1'b0);
        send(32'd10, 1'b1);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
